t3d_abs_slave: RTL and testbench

T3D_ABS_SLAVE -- requirements
Module: t3d_abs_slave

---
 rtl/t3d_abs_slave.sv | 262 ++++++++++++++++++++++++++
 tb/tb_t3d_abs_slave.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/t3d_abs_slave.sv
// t3d_abs_slave: RS485 absolute-encoder slave. Answers a 0x02 request with a
// 6-byte frame {02, status, pos[7:0], pos[15:8], pos[23:16], xor-checksum}.
// Optional feature macro: T3D_ABS_SLAVE_ALARM_EN (adds alarm[7:0] as status).
// Contains its own 8N1 uart_rx / uart_tx.

module uart_rx #(
  parameter int unsigned ClkFrequency = 32400000,
  parameter int unsigned Baud         = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RxD,
  output logic       RxD_data_ready,
  output logic [7:0] RxD_data
);
  localparam int unsigned BitCycles = ClkFrequency / Baud;
  localparam int unsigned CntW      = $clog2(BitCycles + 1);

  logic [1:0]      sync_q;
  logic            active_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      bit_q;
  logic [7:0]      shift_q;
  logic            ready_q;

  // Synchronise the line, find the start edge, sample each bit mid-cell.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], RxD};
      ready_q <= 1'b0;
      if (!active_q) begin
        if (!sync_q[1]) begin
          active_q <= 1'b1;
          cnt_q    <= CntW'(BitCycles / 2);
          bit_q    <= '0;
        end
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CntW'(1);
      end else begin
        cnt_q <= CntW'(BitCycles - 1);
        bit_q <= bit_q + 4'd1;
        if (bit_q == 4'd0) begin
          if (sync_q[1]) active_q <= 1'b0;
        end else if (bit_q <= 4'd8) begin
          shift_q <= {sync_q[1], shift_q[7:1]};
        end else begin
          active_q <= 1'b0;
          ready_q  <= sync_q[1];
        end
      end
    end
  end

  assign RxD_data_ready = ready_q;
  assign RxD_data       = shift_q;
endmodule

module uart_tx #(
  parameter int unsigned ClkFrequency = 32400000,
  parameter int unsigned Baud         = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD,
  output logic       TxD_busy
);
  localparam int unsigned BitCycles = ClkFrequency / Baud;
  localparam int unsigned CntW      = $clog2(BitCycles + 1);

  logic [CntW-1:0] cnt_q;
  logic [3:0]      bit_q;
  logic [9:0]      shift_q;
  logic            busy_q;

  // Shift start, 8 data bits LSB first and stop, one bit per BitCycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      busy_q  <= 1'b0;
    end else if (!busy_q) begin
      if (TxD_start) begin
        busy_q  <= 1'b1;
        shift_q <= {1'b1, TxD_data, 1'b0};
        cnt_q   <= CntW'(BitCycles - 1);
        bit_q   <= '0;
      end
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end else begin
      cnt_q   <= CntW'(BitCycles - 1);
      shift_q <= {1'b1, shift_q[9:1]};
      if (bit_q == 4'd9) busy_q <= 1'b0;
      else               bit_q  <= bit_q + 4'd1;
    end
  end

  assign TxD      = busy_q ? shift_q[0] : 1'b1;
  assign TxD_busy = busy_q;
endmodule

module t3d_abs_slave #(
  parameter int unsigned ClkFrequency = 32400000,
  parameter int unsigned Baud         = 2500000,
  parameter int unsigned TurnCycles   = ClkFrequency / 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        tx,
  output logic        tx_enable,
  input  logic [23:0] position,
`ifdef T3D_ABS_SLAVE_ALARM_EN
  input  logic [7:0]  alarm,
`endif
  output logic        busy,
  output logic [15:0] req_count,
  output logic [15:0] bad_count
);
  localparam int unsigned BitCycles = ClkFrequency / Baud;
  localparam int unsigned MaxCnt    = (TurnCycles > BitCycles) ? TurnCycles : BitCycles;
  localparam int unsigned CntW      = $clog2(MaxCnt + 1);

  typedef enum logic [1:0] {IDLE, TURN, SEND, DRAIN} state_e;

  state_e          state_q;
  logic [23:0]     pos_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      idx_q;
  logic            hold_q;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic            tx_q;
  logic [7:0]      status;
  logic [7:0]      frame_byte;
  logic            rx_ready;
  logic [7:0]      rx_data;
  logic            txd;
  logic            tx_busy;

  uart_rx #(.ClkFrequency(ClkFrequency), .Baud(Baud)) u_rx (
    .clk(clk), .rst_n(rst_n), .RxD(rx),
    .RxD_data_ready(rx_ready), .RxD_data(rx_data)
  );

  uart_tx #(.ClkFrequency(ClkFrequency), .Baud(Baud)) u_tx (
    .clk(clk), .rst_n(rst_n), .TxD_start(tx_start_q), .TxD_data(tx_data_q),
    .TxD(txd), .TxD_busy(tx_busy)
  );

`ifdef T3D_ABS_SLAVE_ALARM_EN
  logic [7:0] alarm_q;
  assign status = alarm_q;
`else
  assign status = 8'h00;
`endif

  // Select the reply byte for the current index; checksum is XOR of bytes 0..4.
  always_comb begin
    frame_byte = 8'h02;
    case (idx_q)
      3'd0:    frame_byte = 8'h02;
      3'd1:    frame_byte = status;
      3'd2:    frame_byte = pos_q[7:0];
      3'd3:    frame_byte = pos_q[15:8];
      3'd4:    frame_byte = pos_q[23:16];
      default: frame_byte = 8'h02 ^ status ^ pos_q[7:0] ^ pos_q[15:8] ^ pos_q[23:16];
    endcase
  end

  // Request/reply sequencer with registered bus control and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_enable  <= 1'b0;
      busy       <= 1'b0;
      req_count  <= '0;
      bad_count  <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      pos_q      <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      hold_q     <= 1'b0;
`ifdef T3D_ABS_SLAVE_ALARM_EN
      alarm_q    <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_enable <= 1'b0;
          hold_q    <= 1'b0;
          if (rx_ready && rx_data == 8'h02) begin
            pos_q     <= position;
`ifdef T3D_ABS_SLAVE_ALARM_EN
            alarm_q   <= alarm;
`endif
            cnt_q     <= CntW'(TurnCycles);
            req_count <= req_count + 16'd1;
            busy      <= 1'b1;
            state_q   <= TURN;
          end else if (rx_ready) begin
            bad_count <= bad_count + 16'd1;
          end
        end
        TURN: begin
          if (cnt_q == '0) begin
            tx_enable <= 1'b1;
            idx_q     <= '0;
            state_q   <= SEND;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        SEND: begin
          // tx_start_q guard covers the cycle before uart_tx raises busy.
          if (!tx_busy && !tx_start_q) begin
            tx_data_q  <= frame_byte;
            tx_start_q <= 1'b1;
            if (idx_q == 3'd5) state_q <= DRAIN;
            else               idx_q   <= idx_q + 3'd1;
          end
        end
        DRAIN: begin
          if (hold_q) begin
            if (cnt_q == '0) begin
              tx_enable <= 1'b0;
              busy      <= 1'b0;
              hold_q    <= 1'b0;
              state_q   <= IDLE;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end else if (!tx_busy && !tx_start_q) begin
            hold_q <= 1'b1;
            cnt_q  <= CntW'(BitCycles - 1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line output idles high whenever the driver is not enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) tx_q <= 1'b1;
    else        tx_q <= tx_enable ? txd : 1'b1;
  end

  assign tx = tx_q;
endmodule

// File: tb/tb_t3d_abs_slave.sv
// Bench for t3d_abs_slave: directed requests, a scoreboard of expected reply
// bytes, and a UART monitor that decodes the tx line and pops/compares.
// Build with T3D_ABS_SLAVE_ALARM_EN to exercise the alarm status path.
`timescale 1ns/1ps
module tb_t3d_abs_slave;
  localparam int unsigned ClkFrequency = 32400000;
  localparam int unsigned Baud         = 2500000;
  localparam int unsigned Bit          = ClkFrequency / Baud;   // 12 cycles

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx;
  logic        tx;
  logic        tx_enable;
  logic [23:0] position;
`ifdef T3D_ABS_SLAVE_ALARM_EN
  logic [7:0]  alarm;
`endif
  logic        busy;
  logic [15:0] req_count;
  logic [15:0] bad_count;

  logic [7:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  t3d_abs_slave #(.ClkFrequency(ClkFrequency), .Baud(Baud)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .tx_enable(tx_enable),
    .position(position),
`ifdef T3D_ABS_SLAVE_ALARM_EN
    .alarm(alarm),
`endif
    .busy(busy), .req_count(req_count), .bad_count(bad_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Decode each byte on the driven bus and compare against the scoreboard.
  initial begin : monitor
    logic [7:0] b;
    logic       stop_bit;
    logic       ok;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (tx_enable === 1'b1 && tx === 1'b0) begin
        ok = 1'b1;
        repeat (Bit / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (Bit) @(negedge clk);
          b[i] = tx;
          if (tx_enable !== 1'b1) ok = 1'b0;
        end
        repeat (Bit) @(negedge clk);
        stop_bit = tx;
        if (tx_enable !== 1'b1) ok = 1'b0;
        if (ok) begin
          n_vec++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_byte: got %02h expected none", b);
          end else begin
            e = exp_q.pop_front();
            if (b !== e || stop_bit !== 1'b1) begin
              n_fail++;
              $display("FAIL reply_byte: got %02h stop %0b expected %02h stop 1", b, stop_bit, e);
            end
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (Bit) @(posedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic push_frame(input logic [47:0] frame);
    for (int i = 5; i >= 0; i--) exp_q.push_back(frame[i*8 +: 8]);
  endtask

  // Issue one request; optionally change position and inject an rx byte mid-reply.
  task automatic do_request(input logic [23:0] pos, input logic [47:0] frame,
                            input logic [23:0] pos_during, input bit inject);
    int n;
    position = pos;
    push_frame(frame);
    send_byte(8'h02);
    n = 0;
    while (tx_enable !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check_range("turn_delay", n, 26, 40);
    position = pos_during;
    if (inject) send_byte(8'h02);
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    check("frame_done", 32'(exp_q.size()), 32'd0);
    n = 0;
    while (tx_enable !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    check_range("drain_delay", n, 14, 24);
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin : stim
    int  n;
    bit  seen;
    rst_n    = 1'b0;
    rx       = 1'b1;
    position = 24'h0;
`ifdef T3D_ABS_SLAVE_ALARM_EN
    alarm    = 8'h00;
`endif
    repeat (5) @(posedge clk);
    #1;
    check("rst_tx_enable", 32'(tx_enable), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_req_count", 32'(req_count), 32'd0);
    check("rst_bad_count", 32'(bad_count), 32'd0);
    check("rst_tx",        32'(tx),        32'd1);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    do_request(24'h123456, 48'h020056341272, 24'h123456, 1'b0);
    check("req_count_1", 32'(req_count), 32'd1);

    do_request(24'hFFFFFF, 48'h0200FFFFFFFD, 24'hFFFFFF, 1'b0);
    check("req_count_2", 32'(req_count), 32'd2);

    // Non-request byte: counted as bad, never answered.
    send_byte(8'h1A);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_enable !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("bad_no_tx",      32'(seen),      32'd0);
    check("bad_count_1",    32'(bad_count), 32'd1);
    check("bad_req_count",  32'(req_count), 32'd2);

    // Frozen frame contents and ignored mid-reply request.
    do_request(24'h000010, 48'h020010000012, 24'h00ABCD, 1'b1);
    check("ignore_req_count", 32'(req_count), 32'd3);
    check("ignore_bad_count", 32'(bad_count), 32'd1);

    // Reset during byte 3 of the reply.
    position = 24'hABCDEF;
    push_frame(48'h0200EFCDAB8B);
    send_byte(8'h02);
    n = 0;
    while (exp_q.size() > 3 && n < 2000) begin @(negedge clk); n++; end
    check("mid_reset_reach_byte3", 32'(exp_q.size()), 32'd3);
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_tx_enable", 32'(tx_enable), 32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_tx",        32'(tx),        32'd1);
    check("mid_rst_req_count", 32'(req_count), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    repeat (150) @(posedge clk);

    do_request(24'h123456, 48'h020056341272, 24'h123456, 1'b0);
    check("post_rst_req_count", 32'(req_count), 32'd1);

`ifdef T3D_ABS_SLAVE_ALARM_EN
    alarm = 8'h80;
    do_request(24'h000001, 48'h028001000083, 24'h000001, 1'b0);
    alarm = 8'h00;
    check("alarm_req_count", 32'(req_count), 32'd2);
`endif

    repeat (300) @(posedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Hard stop so the run always terminates.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
